// File: rtl/w0rm_pkg.sv
// Shared constants and types for the W0RM core memory.
package w0rm_pkg;

   localparam int INST_WIDTH = 16;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   // Default byte address where the core memory is mapped.
   localparam logic [ADDR_WIDTH-1:0] W0RM_MEM_BASE = 32'h2000_0000;

   // Which 16-bit half of a 32-bit word an instruction fetch returns.
   typedef enum logic {
      HALF_LO = 1'b0,
      HALF_HI = 1'b1
   } half_sel_e;

endpackage

// File: rtl/w0rm_dp_ram.sv
// Simple dual-port synchronous RAM: port A read/write, port B read-only.
// Both read ports are registered and hold their value while not enabled.
module w0rm_dp_ram #(
   parameter int WORDS = 1024,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             a_en,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   output logic [WIDTH-1:0] a_rdata,
   input  logic             b_en,
   input  logic [AW-1:0]    b_addr,
   output logic [WIDTH-1:0] b_rdata
);

   // NOTE: the array and its read registers carry no reset so the
   // synthesis tool can map them onto a block RAM; their zero start-up
   // value comes from device configuration, not from rst_n.
   logic [WIDTH-1:0] mem [WORDS];

   // Port A: read-before-write access to the addressed word.
   always_ff @(posedge clk) begin
      if (a_en) begin
         a_rdata <= mem[a_addr];
         if (a_we) begin
            mem[a_addr] <= a_wdata;
         end
      end
   end

   // Port B: registered read; returns the old word on a same-edge write.
   always_ff @(posedge clk) begin
      if (b_en) begin
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/w0rm_core_memory.sv
// Dual-port core memory for the W0RM CPU: a 32-bit load/store bus port
// and a 16-bit instruction fetch port over one shared word array.
// Both ports have one cycle of registered latency and a valid strobe.
module w0rm_core_memory
   import w0rm_pkg::*;
#(
   parameter int                    BLOCK_RAM  = 0,
   parameter int                    ADDR_WIDTH = w0rm_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(W0RM_MEM_BASE),
   parameter int                    MEM_WORDS  = 1024,
   parameter int                    DATA_WIDTH = w0rm_pkg::DATA_WIDTH,
   parameter int                    INST_WIDTH = w0rm_pkg::INST_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic                  inst_read,
   input  logic                  inst_valid_in,
   output logic [INST_WIDTH-1:0] inst_data_out,
   output logic                  inst_valid_out,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic                  bus_read,
   input  logic                  bus_write,
   input  logic                  bus_valid_in,
   input  logic [DATA_WIDTH-1:0] bus_data_in,
   output logic [DATA_WIDTH-1:0] bus_data_out,
   output logic                  bus_valid_out
);

   localparam int WORD_AW = $clog2(MEM_WORDS);
   // Size of the window in bytes, one bit wider so the top of a window
   // that ends exactly at the address-space limit still compares correctly.
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(longint'(MEM_WORDS) * 4);

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] inst_off;
   logic [ADDR_WIDTH-1:0] bus_off;
   logic                  inst_in_range;
   logic                  bus_in_range;
   logic [WORD_AW-1:0]    inst_idx;
   logic [WORD_AW-1:0]    bus_idx;
   logic                  inst_acc;
   logic                  bus_acc;
   logic                  bus_we;

   assign inst_off      = inst_addr - BASE_ADDR;
   assign bus_off       = bus_addr - BASE_ADDR;
   assign inst_in_range = (inst_addr >= BASE_ADDR) && ({1'b0, inst_off} < MEM_BYTES);
   assign bus_in_range  = (bus_addr >= BASE_ADDR) && ({1'b0, bus_off} < MEM_BYTES);

   // Offset bits [1:0] never reach the array: every access is a whole word.
   assign inst_idx = inst_off[WORD_AW+1:2];
   assign bus_idx  = bus_off[WORD_AW+1:2];

   assign inst_acc = inst_valid_in && inst_read;
   assign bus_acc  = bus_valid_in && (bus_read || bus_write);
   // Out-of-range stores are dropped here so they cannot alias into the array.
   assign bus_we   = bus_acc && bus_write && bus_in_range;

   // ------------------------------------------------------------------
   // Storage: registered word reads on both ports
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] a_rdata;
   logic [DATA_WIDTH-1:0] b_rdata;

   if (BLOCK_RAM != 0) begin : g_bram
      w0rm_dp_ram #(
         .WORDS (MEM_WORDS),
         .WIDTH (DATA_WIDTH)
      ) u_ram (
         .clk     (clk),
         .a_en    (bus_acc),
         .a_we    (bus_we),
         .a_addr  (bus_idx),
         .a_wdata (bus_data_in),
         .a_rdata (a_rdata),
         .b_en    (inst_acc),
         .b_addr  (inst_idx),
         .b_rdata (b_rdata)
      );
   end else begin : g_regs
      logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

      // Register-file array: read both ports, then apply the store.
      // NOTE: clearing the whole array on reset is deliberate here; it
      // forces flops instead of RAM, which is what BLOCK_RAM=0 selects.
      // Reads use the pre-edge value because every update is non-blocking.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
               mem[i] <= '0;
            end
            a_rdata <= '0;
            b_rdata <= '0;
         end else begin
            if (bus_acc) begin
               a_rdata <= mem[bus_idx];
            end
            if (inst_acc) begin
               b_rdata <= mem[inst_idx];
            end
            if (bus_we) begin
               mem[bus_idx] <= bus_data_in;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Valid pipeline and per-request side information
   // ------------------------------------------------------------------
   logic      inst_ok_q;
   logic      bus_ok_q;
   half_sel_e inst_half_q;

   // Strobes follow acceptance by one cycle; side info holds between requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_valid_out <= 1'b0;
         bus_valid_out  <= 1'b0;
         inst_ok_q      <= 1'b0;
         bus_ok_q       <= 1'b0;
         inst_half_q    <= HALF_LO;
      end else begin
         inst_valid_out <= inst_acc;
         bus_valid_out  <= bus_acc;
         if (inst_acc) begin
            inst_ok_q   <= inst_in_range;
            inst_half_q <= half_sel_e'(inst_off[1]);
         end
         if (bus_acc) begin
            bus_ok_q <= bus_in_range;
         end
      end
   end

   // Output select: out-of-range requests and reset both force zero data,
   // which also masks the unreset block-RAM read registers.
   always_comb begin
      inst_data_out = '0;
      bus_data_out  = '0;
      if (inst_ok_q) begin
         inst_data_out = (inst_half_q == HALF_HI) ? b_rdata[INST_WIDTH +: INST_WIDTH]
                                                  : b_rdata[0 +: INST_WIDTH];
      end
      if (bus_ok_q) begin
         bus_data_out = a_rdata;
      end
   end

endmodule

// File: tb/tb_w0rm_core_memory.sv
// Scoreboard bench for w0rm_core_memory: one register-array instance and
// one block-RAM instance share all stimulus and a behavioural model.
module tb_w0rm_core_memory;

   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam int          WORDS = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] inst_addr = '0;
   logic        inst_read = 1'b0;
   logic        inst_valid_in = 1'b0;
   logic [31:0] bus_addr = '0;
   logic        bus_read = 1'b0;
   logic        bus_write = 1'b0;
   logic        bus_valid_in = 1'b0;
   logic [31:0] bus_data_in = '0;

   logic [15:0] inst_data_d, inst_data_b;
   logic        inst_valid_d, inst_valid_b;
   logic [31:0] bus_data_d, bus_data_b;
   logic        bus_valid_d, bus_valid_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   w0rm_core_memory #(.BLOCK_RAM(0)) dut_d (
      .clk            (clk),
      .rst_n          (rst_n),
      .inst_addr      (inst_addr),
      .inst_read      (inst_read),
      .inst_valid_in  (inst_valid_in),
      .inst_data_out  (inst_data_d),
      .inst_valid_out (inst_valid_d),
      .bus_addr       (bus_addr),
      .bus_read       (bus_read),
      .bus_write      (bus_write),
      .bus_valid_in   (bus_valid_in),
      .bus_data_in    (bus_data_in),
      .bus_data_out   (bus_data_d),
      .bus_valid_out  (bus_valid_d)
   );

   w0rm_core_memory #(.BLOCK_RAM(1)) dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .inst_addr      (inst_addr),
      .inst_read      (inst_read),
      .inst_valid_in  (inst_valid_in),
      .inst_data_out  (inst_data_b),
      .inst_valid_out (inst_valid_b),
      .bus_addr       (bus_addr),
      .bus_read       (bus_read),
      .bus_write      (bus_write),
      .bus_valid_in   (bus_valid_in),
      .bus_data_in    (bus_data_in),
      .bus_data_out   (bus_data_b),
      .bus_valid_out  (bus_valid_b)
   );

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   // ref_mem mirrors the reset-cleared array; ref_bram mirrors the block
   // RAM, whose words are only predictable once written (known[]).
   logic [31:0] ref_mem  [WORDS];
   logic [31:0] ref_bram [WORDS];
   bit          known    [WORDS];

   // Expected outputs after one request cycle. Data fields are the held
   // output values, so they are meaningful even when no strobe is expected.
   typedef struct {
      bit          iv;
      logic [15:0] id;
      bit          bv;
      logic [31:0] bd;
      bit          ibk;
      logic [15:0] ib;
      bit          bbk;
      logic [31:0] bb;
   } exp_t;

   exp_t exp_q[$];

   logic [15:0] last_id, last_ib;
   logic [31:0] last_bd, last_bb;
   bit          last_ibk, last_bbk;

   function automatic bit in_range(input logic [31:0] a);
      logic [63:0] a64, lo;
      a64 = {32'h0, a};
      lo  = {32'h0, BASE};
      return (a64 >= lo) && (a64 < lo + 64'(4 * WORDS));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
      last_id = '0; last_ib = '0; last_bd = '0; last_bb = '0;
      last_ibk = 1'b1; last_bbk = 1'b1;
      exp_q.delete();
   endtask

   // Drive one cycle of requests and queue what the DUTs must show after it.
   task automatic drive(input bit iv, input bit ir, input logic [31:0] ia,
                        input bit bv, input bit br, input bit bw,
                        input logic [31:0] ba, input logic [31:0] bd);
      exp_t        e;
      logic [31:0] off;
      int          w;
      @(negedge clk);
      inst_valid_in = iv; inst_read = ir; inst_addr = ia;
      bus_valid_in = bv; bus_read = br; bus_write = bw; bus_addr = ba; bus_data_in = bd;

      if (iv && ir) begin
         if (in_range(ia)) begin
            off = ia - BASE;
            w   = int'(off >> 2);
            last_id  = off[1] ? ref_mem[w][31:16]  : ref_mem[w][15:0];
            last_ib  = off[1] ? ref_bram[w][31:16] : ref_bram[w][15:0];
            last_ibk = known[w];
         end else begin
            last_id = '0; last_ib = '0; last_ibk = 1'b1;
         end
      end

      if (bv && (br || bw)) begin
         if (in_range(ba)) begin
            off = ba - BASE;
            w   = int'(off >> 2);
            last_bd  = ref_mem[w];
            last_bb  = ref_bram[w];
            last_bbk = known[w];
            if (bw) begin
               ref_mem[w]  = bd;
               ref_bram[w] = bd;
               known[w]    = 1'b1;
            end
         end else begin
            last_bd = '0; last_bb = '0; last_bbk = 1'b1;
         end
      end

      e.iv = iv && ir;         e.id = last_id;
      e.bv = bv && (br || bw); e.bd = last_bd;
      e.ibk = last_ibk;        e.ib = last_ib;
      e.bbk = last_bbk;        e.bb = last_bb;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic fetch(input logic [31:0] a);
      drive(1'b1, 1'b1, a, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic load(input logic [31:0] a);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, a, '0);
   endtask

   task automatic set_idle_inputs();
      inst_valid_in = 1'b0; inst_read = 1'b0;
      bus_valid_in = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_inst_valid_d"}, 32'(inst_valid_d), 32'h0);
      check({tag, "_inst_data_d"},  32'(inst_data_d),  32'h0);
      check({tag, "_bus_valid_d"},  32'(bus_valid_d),  32'h0);
      check({tag, "_bus_data_d"},   bus_data_d,        32'h0);
      check({tag, "_inst_valid_b"}, 32'(inst_valid_b), 32'h0);
      check({tag, "_inst_data_b"},  32'(inst_data_b),  32'h0);
      check({tag, "_bus_valid_b"},  32'(bus_valid_b),  32'h0);
      check({tag, "_bus_data_b"},   bus_data_b,        32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       return BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      else if (r == 7) return BASE + 32'd4092 + $urandom_range(0, 3);
      else if (r == 8) return BASE + 32'd4096 + ($urandom_range(0, 3) << 2);
      else             return BASE - 32'd4 + $urandom_range(0, 3);
   endfunction

   // ------------------------------------------------------------------
   // Monitor: one scoreboard entry per driven cycle, checked after the edge
   // ------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("inst_valid_d", 32'(inst_valid_d), 32'(e.iv));
            check("inst_data_d",  32'(inst_data_d),  32'(e.id));
            check("bus_valid_d",  32'(bus_valid_d),  32'(e.bv));
            check("bus_data_d",   bus_data_d,        e.bd);
            check("inst_valid_b", 32'(inst_valid_b), 32'(e.iv));
            check("bus_valid_b",  32'(bus_valid_b),  32'(e.bv));
            if (e.ibk) check("inst_data_b", 32'(inst_data_b), 32'(e.ib));
            if (e.bbk) check("bus_data_b",  bus_data_b,       e.bb);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      for (int i = 0; i < WORDS; i++) begin
         ref_bram[i] = '0;
         known[i]    = 1'b0;
      end
      model_reset();

      // Power-on reset; outputs must be zero while held.
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Store then fetch both halves.
      store(BASE, 32'hDEAD_BEEF);
      fetch(BASE);
      fetch(BASE + 32'd2);
      idle();

      // Store / load, plus strobes that must be ignored.
      store(BASE + 32'd4, 32'h1234_5678);
      load(BASE + 32'd4);
      drive(1'b1, 1'b0, BASE, 1'b0, 1'b1, 1'b0, BASE + 32'd4, '0);
      idle();

      // Same-cycle store and fetch of one word returns the old contents.
      drive(1'b1, 1'b1, BASE + 32'd8, 1'b1, 1'b0, 1'b1, BASE + 32'd8, 32'hAAAA_5555);
      fetch(BASE + 32'd8);
      fetch(BASE + 32'd11);
      idle();

      // Range boundaries: stores outside are dropped, last word is live.
      store(32'h1FFF_FFFC, 32'h0BAD_0BAD);
      store(BASE + 32'd4096, 32'h0BAD_F00D);
      store(BASE + 32'd4092, 32'hCAFE_F00D);
      load(32'h1FFF_FFFC);
      load(BASE + 32'd4096);
      load(BASE + 32'd4092);
      fetch(BASE);
      fetch(BASE + 32'd4094);
      fetch(BASE + 32'd4096);
      idle();

      // Back-to-back fetches.
      fetch(BASE);
      fetch(BASE + 32'd2);
      fetch(BASE + 32'd4);
      idle();

      // Combined read+write returns the pre-write word, then the new one.
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, BASE + 32'd4, 32'h5A5A_A5A5);
      load(BASE + 32'd4);
      idle();

      // Randomised traffic on both ports.
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom), 1'($urandom), rand_addr(),
               1'($urandom), 1'($urandom), 1'($urandom), rand_addr(), $urandom);
      end
      idle();

      // Reset while strobes are pending drops everything at once.
      store(BASE, 32'hDEAD_BEEF);
      drive(1'b1, 1'b1, BASE, 1'b1, 1'b1, 1'b0, BASE + 32'd4, '0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      set_idle_inputs();
      #1 check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Register array is cleared; the block RAM keeps its contents.
      fetch(BASE);
      load(BASE + 32'd4);
      idle();
      idle();
      @(posedge clk);
      #2;

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
